// File: rtl/serial_sub_pkg.sv
// Shared constants for the serial subtractor: FSM state encoding and
// the bit-counter width calculation.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full_sub cell processes a - b - bin LSB-first,
// one bit per clock, then presents the difference and ALU flags for a cycle.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             lt,
    output state_t           state
);

    localparam int CW = cnt_width(WIDTH);

    // Handshake: start is accepted on a rising edge whenever the block is in
    // IDLE or DONE (busy=0); it is ignored while busy=1. done is a one-cycle
    // pulse during which diff and the flags are valid; they then hold until
    // the next accepted operation reaches DONE.

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] next_diff;
    logic             last_bit;
    logic             next_ovf;

    full_sub u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (borrow),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // On the final bit a_sr[0]/b_sr[0] hold the operand sign bits.
    assign next_diff = {cell_d, diff_sr[WIDTH-1:1]};
    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign next_ovf  = (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
            lt      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                    diff_sr <= next_diff;
                    borrow  <= cell_bo;
                    cnt     <= cnt + 1'b1;
                    if (last_bit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= next_diff;
                        bout  <= cell_bo;
                        zero  <= (next_diff == '0);
                        neg   <= cell_d;
                        ovf   <= next_ovf;
                        lt    <= cell_d ^ next_ovf;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Randomized and directed bench for serial_sub (WIDTH=8) with a queue-based
// scoreboard fed by the driver and drained by a done-triggered monitor.
module tb_serial_sub;
    import serial_sub_pkg::*;

    localparam int W  = 8;
    localparam int XW = W + 5;
    localparam time PER = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         lt;
    state_t       state;

    int checks = 0;
    int errors = 0;

    logic [XW-1:0] exp_q[$];
    time           exp_t[$];
    int            busy_cnt = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .neg   (neg),
        .ovf   (ovf),
        .lt    (lt),
        .state (state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #(PER / 2) clk = ~clk;
    end

    // Reference model straight from the arithmetic definitions.
    function automatic logic [XW-1:0] model(input logic [W-1:0] av,
                                            input logic [W-1:0] bv,
                                            input logic bi);
        longint       full;
        logic [63:0]  bits;
        logic [W-1:0] d;
        logic         bo;
        logic         z;
        logic         n;
        logic         o;
        full = longint'(av) - longint'(bv) - longint'(bi);
        bits = full;
        d    = bits[W-1:0];
        bo   = (longint'(av) < longint'(bv) + longint'(bi));
        z    = (d == 0);
        n    = d[W-1];
        o    = (av[W-1] != bv[W-1]) && (d[W-1] != av[W-1]);
        return {d, bo, z, n, o, n ^ o};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Driver: issue one operation at a negedge; returns W+1 negedges later,
    // i.e. at the negedge where its done pulse is sampled. poke_at pulses a
    // stray start during RUN; hold keeps start high for a back-to-back op.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bi, input int poke_at, input bit hold);
        start = 1'b1;
        a     = av;
        b     = bv;
        bin   = bi;
        exp_q.push_back(model(av, bv, bi));
        exp_t.push_back($time + PER * (W + 1));
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            start = hold || (k == poke_at);
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
            end else begin
                check("result", {diff, bout, zero, neg, ovf, lt}, exp_q.pop_front());
                check("done_time", $time, exp_t.pop_front());
                check("busy_cycles", busy_cnt, W);
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
    end

    initial begin
        bit hold;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #3;
        check("reset_outputs", {busy, done, diff, bout, zero, neg, ovf, lt}, '0);
        check("reset_state", state, IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("idle_no_done", {busy, done}, 2'b00);

        // Directed cases
        do_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
        idle(1);
        do_op(8'h03, 8'h05, 1'b0, 0, 1'b0);
        idle(2);
        do_op(8'h80, 8'h01, 1'b0, 0, 1'b0);
        idle(1);
        do_op(8'h55, 8'h55, 1'b0, 0, 1'b0);
        idle(1);
        do_op(8'h00, 8'hFF, 1'b1, 0, 1'b0);
        check("flags_hold_idle", {diff, bout, zero}, {8'h00, 1'b1, 1'b1});
        idle(1);
        do_op(8'hFF, 8'h00, 1'b1, 0, 1'b0);
        idle(1);

        // Stray start in RUN cycle 3, then back-to-back with start held
        do_op(8'h9C, 8'h27, 1'b0, 3, 1'b0);
        idle(1);
        do_op(8'h12, 8'h34, 1'b1, 0, 1'b1);
        do_op(8'h7F, 8'h80, 1'b0, 0, 1'b1);
        do_op(8'h40, 8'hC0, 1'b1, 0, 1'b0);
        idle(1);
        check("flags_after_b2b", {diff, neg}, {8'h7F, 1'b0});

        // Reset in RUN cycle 4 aborts the operation
        start = 1'b1;
        a     = 8'h3C;
        b     = 8'h11;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {busy, done, diff, bout, zero, neg, ovf, lt}, '0);
        check("async_reset_state", state, IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(W + 3);
        check("post_reset_quiet", {busy, done, diff}, '0);
        do_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0);
        idle(1);

        // Randomized operations with random gaps and back-to-back runs
        for (int i = 0; i < 40; i++) begin
            hold = (i != 39) && ($urandom_range(0, 3) == 0);
            do_op(W'($urandom), W'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W - 1)) : 0, hold);
            if (!hold) idle($urandom_range(0, 2));
        end

        idle(W + 4);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
